// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared unsigned adder into a single-entry
// response register with valid/ready handshake on the response side.
module adder_arbiter #(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_REQ    = 4,
   localparam int IDW       = $clog2(NUM_REQ)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_A,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_B,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic                          o_rsp_valid,
   output logic [DATA_WIDTH:0]           o_rsp_X,
   output logic [IDW-1:0]                o_rsp_id,
   input  logic                          i_rsp_ready
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t                state_q, state_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [DATA_WIDTH:0]   x_q, x_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [IDW-1:0]        gnt_id;
   logic                  gnt_any;
   logic                  can_accept;
   logic                  grant;
   logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
   logic [DATA_WIDTH-1:0] op_b [NUM_REQ];
   logic [DATA_WIDTH:0]   sum;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign op_a[k] = i_req_A[k*DATA_WIDTH +: DATA_WIDTH];
      assign op_b[k] = i_req_B[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // First valid requester at or after the pointer, wrapping to 0.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_any && i_req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(idx);
         end
      end
   end

   // Reset gates the grant so o_req_ready is low while i_rst is held.
   assign can_accept = (state_q == EMPTY) || i_rsp_ready;
   assign grant      = can_accept && gnt_any && !i_rst;

   always_comb begin
      o_req_ready = '0;
      if (grant) o_req_ready[gnt_id] = 1'b1;
   end

   assign sum = {1'b0, op_a[gnt_id]} + {1'b0, op_b[gnt_id]};

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      x_d     = x_q;
      id_d    = id_q;
      if (grant) begin
         state_d = FULL;
         x_d     = sum;
         id_d    = gnt_id;
         ptr_d   = (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + IDW'(1);
      end else if (state_q == FULL && i_rsp_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         x_q     <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         x_q     <= x_d;
         id_q    <= id_d;
      end
   end

   assign o_rsp_valid = (state_q == FULL);
   assign o_rsp_X     = x_q;
   assign o_rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: stimulus pushes expected {id,sum} per grant; a monitor pops
// and compares whenever a response handshake occurs.
module tb_adder_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid;
   logic [15:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [4:0]  rsp_x;
   logic [1:0]  rsp_id;
   logic        rsp_ready;

   int checks   = 0;
   int failures = 0;
   logic [6:0] exp_q [$];

   always #5 clk = ~clk;

   adder_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_A     (req_a),
      .i_req_B     (req_b),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .o_rsp_X     (rsp_x),
      .o_rsp_id    (rsp_id),
      .i_rsp_ready (rsp_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Drive one cycle; check the grant at negedge and queue the expected response.
   task automatic step(input logic [3:0] v, input logic rdy, input logic [3:0] eg,
                       input logic [4:0] ex);
      logic [1:0] id;
      id        = '0;
      req_valid = v;
      rsp_ready = rdy;
      @(negedge clk);
      chk("grant", {28'd0, req_ready}, {28'd0, eg});
      if (eg != 4'd0) begin
         for (int k = 0; k < 4; k++) if (eg[k]) id = k[1:0];
         exp_q.push_back({id, ex});
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [6:0] e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual=%0d expected=none", rsp_x);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_x", {27'd0, rsp_x}, {27'd0, e[4:0]});
            chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[6:5]});
         end
      end
   end

   initial begin
      // Operands per requester: 0:1+2=3, 1:9+8=17, 2:15+15=30, 3:0+0=0
      req_a     = 16'h0F91;
      req_b     = 16'h0F82;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #12;
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_x", {27'd0, rsp_x}, 32'd0);
      chk("rst_id", {30'd0, rsp_id}, 32'd0);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      step(4'b0010, 1'b1, 4'b0010, 5'd17);
      step(4'b1111, 1'b1, 4'b0100, 5'd30);
      step(4'b1111, 1'b1, 4'b1000, 5'd0);
      step(4'b1111, 1'b1, 4'b0001, 5'd3);
      step(4'b1111, 1'b1, 4'b0010, 5'd17);
      step(4'b1111, 1'b1, 4'b0100, 5'd30);
      // pointer now 3: req3 wins over req0, then wraps to req0
      step(4'b1001, 1'b1, 4'b1000, 5'd0);
      step(4'b1001, 1'b1, 4'b0001, 5'd3);

      // backpressure: result 3/id0 must hold
      repeat (3) begin
         step(4'b0100, 1'b0, 4'b0000, 5'd0);
         chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_x", {27'd0, rsp_x}, 32'd3);
         chk("hold_id", {30'd0, rsp_id}, 32'd0);
      end
      step(4'b0100, 1'b1, 4'b0100, 5'd30);
      step(4'b0000, 1'b1, 4'b0000, 5'd0);
      chk("drained_valid", {31'd0, rsp_valid}, 32'd0);

      // fill with pointer left at 3, then reset mid-cycle
      step(4'b0100, 1'b0, 4'b0100, 5'd30);
      chk("full_before_rst", {31'd0, rsp_valid}, 32'd1);
      req_valid = 4'b0000;
      rsp_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("midrst_x", {27'd0, rsp_x}, 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(4'b1100, 1'b1, 4'b0100, 5'd30);
      step(4'b1100, 1'b1, 4'b1000, 5'd0);
      step(4'b0000, 1'b1, 4'b0000, 5'd0);
      step(4'b0000, 1'b1, 4'b0000, 5'd0);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, meaning operand width in bits (1..32).
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning number of requesters (2..8); IDW = $clog2(NUM_REQ).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_req_valid  input  NUM_REQ  bit k = requester k presents an operand pair.
REQ-006 SHALL have port i_req_A  input  NUM_REQ*DATA_WIDTH  operand A of requester k in bits [k*DATA_WIDTH +: DATA_WIDTH], unsigned.
REQ-007 SHALL have port i_req_B  input  NUM_REQ*DATA_WIDTH  operand B, same packing, unsigned.
REQ-008 SHALL have port o_req_ready  output  NUM_REQ  bit k = requester k is granted this cycle.
REQ-009 SHALL have port o_rsp_valid  output  1  result register holds a result.
REQ-010 SHALL have port o_rsp_X  output  DATA_WIDTH+1  sum, including carry-out bit.
REQ-011 SHALL have port o_rsp_id  output  IDW  index of the requester that produced o_rsp_X.
REQ-012 SHALL have port i_rsp_ready  input  1  consumer accepts the response.

Function
REQ-013 SHALL share one DATA_WIDTH-bit unsigned adder among all requesters; o_rsp_X = A + B, zero-extended operands, carry in bit DATA_WIDTH, no truncation or overflow flag.
REQ-014 SHALL implement a two-state FSM: EMPTY (o_rsp_valid=0) and FULL (o_rsp_valid=1).
REQ-015 SHALL compute can_accept = EMPTY, or FULL with i_rsp_ready=1 (same-cycle drain and refill).
REQ-016 SHALL, when can_accept and any i_req_valid bit set, assert exactly one o_req_ready bit, chosen round-robin; otherwise o_req_ready = 0.
REQ-017 SHALL search round-robin starting at pointer P, ascending, wrapping NUM_REQ-1 -> 0; first valid requester wins.
REQ-018 SHALL, on a grant to requester g, set P to (g+1) mod NUM_REQ at the clock edge; P unchanged when no grant.
REQ-019 SHALL derive o_req_ready combinationally from i_req_valid, P and FSM state; o_req_ready[k] never asserted while i_req_valid[k]=0.
REQ-020 SHALL, on a grant, register the sum and g into o_rsp_X/o_rsp_id at the same edge; o_rsp_valid asserted the following cycle (latency 1 cycle from transfer to response).
REQ-021 SHALL transition EMPTY->FULL on grant; FULL->EMPTY on i_rsp_ready with no grant; FULL->FULL on i_rsp_ready with grant (new result loaded) or on no i_rsp_ready (hold).
REQ-022 SHALL hold o_rsp_X and o_rsp_id stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-023 SHALL ignore i_rsp_ready while EMPTY.
REQ-024 SHALL treat a requester deasserting i_req_valid before grant as withdrawn; no state change.
REQ-025 SHALL sustain one result per cycle when i_rsp_ready is held high and requests are pending.

Reset
REQ-026 SHALL, while i_rst=1, force FSM to EMPTY, P=0, o_rsp_valid=0, o_rsp_X=0, o_rsp_id=0, o_req_ready=0, independent of i_clk.
REQ-027 SHALL discard any held result when reset asserts mid-operation; first grant after release starts search at requester 0.

Verification
REQ-028 SHALL pass: reset release, NUM_REQ=4, DW=4, only req1 valid A=9 B=8, i_rsp_ready=1 -> o_req_ready=0010 same cycle; next cycle o_rsp_valid=1, X=17, id=1.
REQ-029 SHALL pass: all four valid continuously, i_rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; one response per cycle with matching id.
REQ-030 SHALL pass: FULL with i_rsp_ready=0 for 3 cycles, req2 valid -> o_req_ready=0, X/id stable; i_rsp_ready=1 -> req2 granted that cycle, its result next cycle.
REQ-031 SHALL pass: A=15 B=15 -> X=30 (carry bit set); A=0 B=0 -> X=0.
REQ-032 SHALL pass: P=3, req0 and req3 valid -> req3 granted, P becomes 0, next grant req0.
REQ-033 SHALL pass: i_rst asserted mid-cycle while FULL -> o_rsp_valid drops immediately without clock edge; after release req2,req3 valid -> req2 granted first.
